// File: rtl/lift_scheduler.sv
// lift_scheduler: SCAN elevator controller, IDLE/MOVE/DOOR FSM, all outputs registered.
// Optional macro LIFT_DOOR_HOLD_EN: a call for the open-door floor re-arms the door timer.
module lift_scheduler #(
   parameter int FLOORS       = 9,
   parameter int TRAVEL_TICKS = 50000000,
   parameter int DOOR_TICKS   = 150000000
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic [8:0] SW,
   input  logic       REQ_VALID,
   output logic [3:0] FLOOR_CUR,
   output logic [3:0] FLOOR_TGT,
   output logic [8:0] PENDING,
   output logic [1:0] DIR,
   output logic       LED_G,
   output logic       LED_R
);
   localparam int TW = $clog2(TRAVEL_TICKS + 1);
   localparam int DW = $clog2(DOOR_TICKS + 1);
   localparam logic [1:0] DIR_STOP = 2'd0;
   localparam logic [1:0] DIR_UP   = 2'd1;
   localparam logic [1:0] DIR_DOWN = 2'd2;
   localparam logic [8:0] FLOOR_MASK = 9'((1 << FLOORS) - 1);

`ifdef LIFT_DOOR_HOLD_EN
   localparam bit HoldEn = 1'b1;
`else
   localparam bit HoldEn = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   state_t        state_q, state_d;
   logic [3:0]    floor_q, floor_d;
   logic [3:0]    tgt_q, tgt_d;
   logic [8:0]    pend_q, pend_d;
   logic [1:0]    dir_q, dir_d;
   logic          ledg_q, ledg_d;
   logic [TW-1:0] travel_q, travel_d;
   logic [DW-1:0] door_q, door_d;

   logic [8:0] above, below, newReq, served;
   logic [3:0] nextFloor;
   logic       doorHold;

   assign above     = pend_q & ~((9'd2 << floor_q) - 9'd1);
   assign below     = pend_q & ((9'd1 << floor_q) - 9'd1);
   assign nextFloor = (dir_q == DIR_DOWN) ? floor_q - 4'd1 : floor_q + 4'd1;

   // Target lags PENDING by one cycle: nearest pending floor strictly ahead in DIR.
   always_comb begin
      tgt_d = floor_q;
      if (dir_q == DIR_UP) begin
         for (int k = FLOORS - 1; k >= 0; k--)
            if (above[k]) tgt_d = 4'(k);
      end else if (dir_q == DIR_DOWN) begin
         for (int k = 0; k < FLOORS; k++)
            if (below[k]) tgt_d = 4'(k);
      end
   end

   always_comb begin
      state_d  = state_q;
      floor_d  = floor_q;
      dir_d    = dir_q;
      travel_d = travel_q;
      door_d   = door_q;
      served   = '0;
      doorHold = 1'b0;
      newReq   = REQ_VALID ? (SW & FLOOR_MASK) : '0;
      // A call for the floor whose door is open is never latched.
      if (state_q == DOOR && newReq[floor_q]) begin
         doorHold        = 1'b1;
         newReq[floor_q] = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (pend_q[floor_q]) begin
               state_d         = DOOR;
               served[floor_q] = 1'b1;
               door_d          = DW'(DOOR_TICKS);
            end else if (pend_q != '0) begin
               state_d  = MOVE;
               dir_d    = (above != '0) ? DIR_UP : DIR_DOWN;
               travel_d = TW'(TRAVEL_TICKS);
            end
         end
         MOVE: begin
            if (travel_q == TW'(1)) begin
               floor_d  = nextFloor;
               travel_d = TW'(TRAVEL_TICKS);
               if (pend_q[nextFloor]) begin
                  state_d           = DOOR;
                  served[nextFloor] = 1'b1;
                  door_d            = DW'(DOOR_TICKS);
               end
            end else begin
               travel_d = travel_q - TW'(1);
            end
         end
         DOOR: begin
            if (HoldEn && doorHold) begin
               door_d = DW'(DOOR_TICKS);
            end else if (door_q == DW'(1)) begin
               door_d   = '0;
               state_d  = MOVE;
               travel_d = TW'(TRAVEL_TICKS);
               if (dir_q == DIR_UP && above != '0)         dir_d = DIR_UP;
               else if (dir_q == DIR_DOWN && below != '0)  dir_d = DIR_DOWN;
               else if (above != '0)                       dir_d = DIR_UP;
               else if (below != '0)                       dir_d = DIR_DOWN;
               else begin
                  dir_d    = DIR_STOP;
                  state_d  = IDLE;
                  travel_d = '0;
               end
            end else begin
               door_d = door_q - DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      pend_d = (pend_q | newReq) & ~served;
      ledg_d = (state_d == DOOR);
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state_q  <= IDLE;
         floor_q  <= '0;
         tgt_q    <= '0;
         pend_q   <= '0;
         dir_q    <= DIR_STOP;
         ledg_q   <= 1'b0;
         travel_q <= '0;
         door_q   <= '0;
      end else begin
         state_q  <= state_d;
         floor_q  <= floor_d;
         tgt_q    <= tgt_d;
         pend_q   <= pend_d;
         dir_q    <= dir_d;
         ledg_q   <= ledg_d;
         travel_q <= travel_d;
         door_q   <= door_d;
      end
   end

   assign FLOOR_CUR = floor_q;
   assign FLOOR_TGT = tgt_q;
   assign PENDING   = pend_q;
   assign DIR       = dir_q;
   assign LED_G     = ledg_q;
   assign LED_R     = ~ledg_q;

endmodule

// File: tb/tb_lift_scheduler.sv
// tb_lift_scheduler: directed scenarios plus randomized traffic checked against a
// behavioural SCAN model; honours LIFT_DOOR_HOLD_EN like the design.
module tb_lift_scheduler;
   localparam int FLOORS = 9;
   localparam int TRAVEL = 4;
   localparam int DOOR   = 3;

`ifdef LIFT_DOOR_HOLD_EN
   localparam bit HoldEnabled = 1'b1;
`else
   localparam bit HoldEnabled = 1'b0;
`endif

   typedef enum int {M_IDLE, M_MOVE, M_DOOR} mode_t;

   logic       CLOCK_50 = 1'b0;
   logic       RESET = 1'b0;
   logic       REQ_VALID = 1'b0;
   logic [8:0] SW = '0;
   logic [3:0] FLOOR_CUR, FLOOR_TGT;
   logic [8:0] PENDING;
   logic [1:0] DIR;
   logic       LED_G, LED_R;

   int testsRun = 0;
   int testsFailed = 0;

   mode_t mMode = M_IDLE;
   int    mFloor = 0, mDir = 0, mTgt = 0, mTimer = 0;
   bit    mPend[FLOORS];

   lift_scheduler #(.FLOORS(FLOORS), .TRAVEL_TICKS(TRAVEL), .DOOR_TICKS(DOOR)) dut (
      .CLOCK_50(CLOCK_50), .RESET(RESET), .SW(SW), .REQ_VALID(REQ_VALID),
      .FLOOR_CUR(FLOOR_CUR), .FLOOR_TGT(FLOOR_TGT), .PENDING(PENDING),
      .DIR(DIR), .LED_G(LED_G), .LED_R(LED_R)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic int stepOf(input int d);
      return (d == 2) ? -1 : 1;
   endfunction

   function automatic int pendingBeyond(input int from, input int step);
      int n = 0;
      for (int k = from + step; k >= 0 && k < FLOORS; k += step)
         if (mPend[k]) n++;
      return n;
   endfunction

   function automatic int nearestBeyond(input int from, input int step);
      for (int k = from + step; k >= 0 && k < FLOORS; k += step)
         if (mPend[k]) return k;
      return from;
   endfunction

   function automatic logic [8:0] pendVec();
      logic [8:0] v = '0;
      for (int k = 0; k < FLOORS; k++) v[k] = mPend[k];
      return v;
   endfunction

   // Reference model: advances one clock using the lift's rules on floors and timers.
   task automatic modelStep(input bit r, input bit v, input logic [8:0] s);
      bit req[FLOORS];
      bit hold = 0;
      int served = -1;
      int newTgt;
      if (r) begin
         mMode = M_IDLE; mFloor = 0; mDir = 0; mTgt = 0; mTimer = 0;
         for (int k = 0; k < FLOORS; k++) mPend[k] = 0;
         return;
      end
      newTgt = (mDir == 0) ? mFloor : nearestBeyond(mFloor, stepOf(mDir));
      for (int k = 0; k < FLOORS; k++) req[k] = v && s[k];
      if (mMode == M_DOOR && req[mFloor]) begin
         req[mFloor] = 0;
         hold = 1;
      end
      case (mMode)
         M_IDLE: begin
            if (mPend[mFloor]) begin
               mMode = M_DOOR; served = mFloor; mTimer = DOOR;
            end else if (pendingBeyond(mFloor, 1) + pendingBeyond(mFloor, -1) > 0) begin
               mMode = M_MOVE; mTimer = TRAVEL;
               mDir = (pendingBeyond(mFloor, 1) > 0) ? 1 : 2;
            end
         end
         M_MOVE: begin
            mTimer--;
            if (mTimer == 0) begin
               mFloor += stepOf(mDir);
               mTimer = TRAVEL;
               if (mPend[mFloor]) begin
                  mMode = M_DOOR; served = mFloor; mTimer = DOOR;
               end
            end
         end
         default: begin
            if (hold && HoldEnabled) mTimer = DOOR;
            else begin
               mTimer--;
               if (mTimer == 0) begin
                  if (mDir != 0 && pendingBeyond(mFloor, stepOf(mDir)) > 0) ;
                  else if (pendingBeyond(mFloor, 1) > 0)  mDir = 1;
                  else if (pendingBeyond(mFloor, -1) > 0) mDir = 2;
                  else mDir = 0;
                  mMode  = (mDir == 0) ? M_IDLE : M_MOVE;
                  mTimer = TRAVEL;
               end
            end
         end
      endcase
      for (int k = 0; k < FLOORS; k++) mPend[k] = (mPend[k] || req[k]) && (k != served);
      mTgt = newTgt;
   endtask

   // Inputs are held for one cycle, then outputs are sampled 1 time unit after the edge.
   task automatic tick(input bit r, input bit v, input logic [8:0] s);
      RESET = r; REQ_VALID = v; SW = s;
      @(posedge CLOCK_50);
      modelStep(r, v, s);
      #1;
      RESET = 1'b0; REQ_VALID = 1'b0; SW = '0;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, '0);
      testsRun++; if (FLOOR_CUR !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_floor: got %0d want 0", FLOOR_CUR); end
      testsRun++; if (FLOOR_TGT !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_tgt: got %0d want 0", FLOOR_TGT); end
      testsRun++; if (PENDING !== 9'h000) begin testsFailed++; $display("[TB] FAIL reset_pending: got %h want 000", PENDING); end
      testsRun++; if (DIR !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_dir: got %0d want 0", DIR); end
      testsRun++; if (LED_G !== 1'b0 || LED_R !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_leds: got G=%b R=%b want G=0 R=1", LED_G, LED_R); end
      tick(1'b1, 1'b1, 9'h1FF);
      testsRun++; if (PENDING !== 9'h000) begin testsFailed++; $display("[TB] FAIL reset_priority: got %h want 000", PENDING); end
   endtask

   task automatic test_single_request();
      int moveCycles = 0;
      int doorCycles = 0;
      tick(1'b0, 1'b1, 9'h008);
      testsRun++; if (PENDING !== 9'h008 || DIR !== 2'd0) begin testsFailed++; $display("[TB] FAIL single_latch: got pend=%h dir=%0d want 008/0", PENDING, DIR); end
      tick(1'b0, 1'b0, '0);
      testsRun++; if (DIR !== 2'd1) begin testsFailed++; $display("[TB] FAIL single_dir_up: got %0d want 1", DIR); end
      for (int i = 0; i < 100 && FLOOR_CUR !== 4'd3; i++) begin
         if (!LED_G) moveCycles++;
         tick(1'b0, 1'b0, '0);
      end
      testsRun++; if (moveCycles != 12) begin testsFailed++; $display("[TB] FAIL single_move_cycles: got %0d want 12", moveCycles); end
      testsRun++; if (FLOOR_CUR !== 4'd3 || LED_G !== 1'b1 || FLOOR_TGT !== 4'd3) begin testsFailed++; $display("[TB] FAIL single_arrive: got floor=%0d G=%b tgt=%0d want 3/1/3", FLOOR_CUR, LED_G, FLOOR_TGT); end
      for (int i = 0; i < 50 && LED_G === 1'b1; i++) begin
         doorCycles++;
         tick(1'b0, 1'b0, '0);
      end
      testsRun++; if (doorCycles != 3) begin testsFailed++; $display("[TB] FAIL single_door_cycles: got %0d want 3", doorCycles); end
      testsRun++; if (PENDING !== 9'h000 || DIR !== 2'd0 || LED_R !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_idle: got pend=%h dir=%0d R=%b want 000/0/1", PENDING, DIR, LED_R); end
   endtask

   task automatic test_scan_order();
      int stops[$];
      int dirs[$];
      int expStops[3] = '{4, 6, 1};
      int expDirs[3]  = '{1, 2, 0};
      logic prevG;
      int got;
      tick(1'b1, 1'b0, '0);
      tick(1'b0, 1'b1, 9'h040);
      for (int i = 0; i < 100 && FLOOR_CUR !== 4'd2; i++) tick(1'b0, 1'b0, '0);
      testsRun++; if (FLOOR_CUR !== 4'd2 || DIR !== 2'd1) begin testsFailed++; $display("[TB] FAIL scan_reach2: got floor=%0d dir=%0d want 2/1", FLOOR_CUR, DIR); end
      tick(1'b0, 1'b1, 9'h012);
      dirs.push_back(int'(DIR));
      prevG = LED_G;
      for (int i = 0; i < 400 && !(DIR === 2'd0 && LED_G === 1'b0 && PENDING === 9'h000); i++) begin
         tick(1'b0, 1'b0, '0);
         if (LED_G && !prevG) stops.push_back(int'(FLOOR_CUR));
         if (int'(DIR) != dirs[dirs.size()-1]) dirs.push_back(int'(DIR));
         prevG = LED_G;
      end
      testsRun++; if (stops.size() != 3) begin testsFailed++; $display("[TB] FAIL scan_stop_count: got %0d want 3", stops.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < stops.size()) ? stops[i] : -1;
         testsRun++; if (got != expStops[i]) begin testsFailed++; $display("[TB] FAIL scan_stop%0d: got %0d want %0d", i, got, expStops[i]); end
         got = (i < dirs.size()) ? dirs[i] : -1;
         testsRun++; if (got != expDirs[i]) begin testsFailed++; $display("[TB] FAIL scan_dir%0d: got %0d want %0d", i, got, expDirs[i]); end
      end
   endtask

   task automatic test_idle_at_floor();
      tick(1'b1, 1'b0, '0);
      tick(1'b0, 1'b1, 9'h020);
      for (int i = 0; i < 300 && !(FLOOR_CUR === 4'd5 && DIR === 2'd0 && LED_G === 1'b0); i++) tick(1'b0, 1'b0, '0);
      testsRun++; if (FLOOR_CUR !== 4'd5 || DIR !== 2'd0 || LED_G !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle5_reach: got floor=%0d dir=%0d G=%b want 5/0/0", FLOOR_CUR, DIR, LED_G); end
      tick(1'b0, 1'b1, 9'h020);
      testsRun++; if (PENDING !== 9'h020) begin testsFailed++; $display("[TB] FAIL idle5_latch: got %h want 020", PENDING); end
      tick(1'b0, 1'b0, '0);
      testsRun++; if (LED_G !== 1'b1 || FLOOR_CUR !== 4'd5 || DIR !== 2'd0 || PENDING !== 9'h000) begin testsFailed++; $display("[TB] FAIL idle5_door: got G=%b floor=%0d dir=%0d pend=%h want 1/5/0/000", LED_G, FLOOR_CUR, DIR, PENDING); end
   endtask

   task automatic test_reset_mid_move();
      bit moved = 0;
      tick(1'b1, 1'b0, '0);
      tick(1'b0, 1'b1, 9'h100);
      for (int i = 0; i < 200 && FLOOR_CUR !== 4'd4; i++) tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b0, '0);
      testsRun++; if (FLOOR_CUR !== 4'd4 || PENDING !== 9'h100 || DIR !== 2'd1) begin testsFailed++; $display("[TB] FAIL midmove_setup: got floor=%0d pend=%h dir=%0d want 4/100/1", FLOOR_CUR, PENDING, DIR); end
      tick(1'b1, 1'b0, '0);
      testsRun++; if ({FLOOR_CUR, FLOOR_TGT, PENDING, DIR, LED_G, LED_R} !== {4'd0, 4'd0, 9'h000, 2'd0, 1'b0, 1'b1}) begin testsFailed++; $display("[TB] FAIL midmove_reset: got floor=%0d tgt=%0d pend=%h dir=%0d G=%b R=%b", FLOOR_CUR, FLOOR_TGT, PENDING, DIR, LED_G, LED_R); end
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 1'b0, '0);
         if (FLOOR_CUR !== 4'd0 || DIR !== 2'd0) moved = 1;
      end
      testsRun++; if (moved) begin testsFailed++; $display("[TB] FAIL midmove_still: got motion=1 want 0"); end
   endtask

   task automatic test_door_hold();
      int openCycles = 0;
      int expOpen = HoldEnabled ? 5 : 3;
      tick(1'b1, 1'b0, '0);
      tick(1'b0, 1'b1, 9'h004);
      for (int i = 0; i < 100 && LED_G !== 1'b1; i++) tick(1'b0, 1'b0, '0);
      testsRun++; if (FLOOR_CUR !== 4'd2 || LED_G !== 1'b1) begin testsFailed++; $display("[TB] FAIL hold_open: got floor=%0d G=%b want 2/1", FLOOR_CUR, LED_G); end
      openCycles = 1;
      tick(1'b0, 1'b0, '0);
      if (LED_G) openCycles++;
      tick(1'b0, 1'b1, 9'h004);
      testsRun++; if (PENDING !== 9'h000) begin testsFailed++; $display("[TB] FAIL hold_pending: got %h want 000", PENDING); end
      for (int i = 0; i < 50 && LED_G === 1'b1; i++) begin
         openCycles++;
         tick(1'b0, 1'b0, '0);
      end
      testsRun++; if (openCycles != expOpen) begin testsFailed++; $display("[TB] FAIL hold_door_cycles: got %0d want %0d", openCycles, expOpen); end
   endtask

   task automatic test_random();
      logic [22:0] got, want;
      bit r, v;
      logic [8:0] s;
      tick(1'b1, 1'b0, '0);
      for (int i = 0; i < 4000 && testsFailed < 20; i++) begin
         r = ($urandom_range(0, 599) == 0);
         v = ($urandom_range(0, 11) == 0);
         s = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'(1 << $urandom_range(0, 8));
         tick(r, v, s);
         got  = {FLOOR_CUR, FLOOR_TGT, PENDING, DIR, LED_G, LED_R, 1'b0};
         want = {4'(mFloor), 4'(mTgt), pendVec(), 2'(mDir), mMode == M_DOOR, mMode != M_DOOR, 1'b0};
         testsRun++;
         if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL random_cycle%0d: got floor=%0d tgt=%0d pend=%h dir=%0d G=%b R=%b want floor=%0d tgt=%0d pend=%h dir=%0d G=%b",
                     i, FLOOR_CUR, FLOOR_TGT, PENDING, DIR, LED_G, LED_R, mFloor, mTgt, pendVec(), mDir, mMode == M_DOOR);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_request();
      test_scan_order();
      test_idle_at_floor();
      test_reset_mid_move();
      test_door_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
